// File: rtl/crossbar_pipe.sv
// ---------------------------------------------------------------------------
// crossbar_pipe -- operand crossbar for the RMT action stage.
//
// The PHV is split into N_CONT containers of CONT_W bits. Action slot k+1
// drives container k: its opcode chooses up to four ALU operands (A, B, C, D)
// from other containers, the immediate field, or the stateful data field.
// Decoded operands, the PHV tail and the full action word are registered
// together, so the ALU array sees operands and action aligned. A two-entry
// output/skid structure provides a registered in_ready.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   phv_in            PHV; container k at [REM_W+(k+1)*CONT_W-1 -: CONT_W],
//                     tail at [REM_W-1:0]
//   action_in         action slots; slot s at [s*ACT_LEN +: ACT_LEN]
//   in_valid/in_ready input handshake (in_ready is registered)
//   alu_a..alu_d      operand k at [(k+1)*CONT_W-1 -: CONT_W]
//   phv_remain_data   registered PHV tail
//   action_out        action word aligned with the operands
//   out_valid/out_ready output handshake
//   idx_err           sticky out-of-range source index flag
//
// Optional feature (macro CROSSBAR_IDX_CHECK_EN): a used source index
// >= N_CONT selects container 0 and sets idx_err until reset. Without the
// macro, indices are used as-is and idx_err is tied 0.
// ---------------------------------------------------------------------------
module crossbar_pipe #(
  parameter int STAGE_ID = 0,
  parameter int N_CONT   = 64,
  parameter int CONT_W   = 32,
  parameter int REM_W    = 256,
  parameter int ACT_LEN  = 64,
  parameter int IDX_W    = $clog2(N_CONT),
  parameter int PHV_LEN  = N_CONT*CONT_W+REM_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic [ACT_LEN*(N_CONT+1)-1:0] action_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [N_CONT*CONT_W-1:0]      alu_a,
  output logic [N_CONT*CONT_W-1:0]      alu_b,
  output logic [N_CONT*CONT_W-1:0]      alu_c,
  output logic [N_CONT*CONT_W-1:0]      alu_d,
  output logic [REM_W-1:0]              phv_remain_data,
  output logic [ACT_LEN*(N_CONT+1)-1:0] action_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          idx_err
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int OPW   = N_CONT*CONT_W;
  localparam int AW    = ACT_LEN*(N_CONT+1);

  typedef struct packed {
    logic [OPW-1:0]   a;
    logic [OPW-1:0]   b;
    logic [OPW-1:0]   c;
    logic [OPW-1:0]   d;
    logic [REM_W-1:0] rem;
    logic [AW-1:0]    act;
  } beat_t;

  typedef enum logic [1:0] {A_SELF, A_SA, A_ZERO}         a_sel_e;
  typedef enum logic [1:0] {B_ZERO, B_SB, B_IMM}          b_sel_e;
  typedef enum logic [1:0] {C_SELF, C_SC, C_IMM}          c_sel_e;
  typedef enum logic       {D_SELF, D_DFIELD}             d_sel_e;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL}       state_e;

  // Container table padded to a power of two so every IDX_W-bit index is
  // in range; padding entries read as zero.
  logic [CONT_W-1:0] w_cont [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_cont
    if (g < N_CONT) begin : g_real
      assign w_cont[g] = phv_in[REM_W+(g+1)*CONT_W-1 -: CONT_W];
    end else begin : g_pad
      assign w_cont[g] = '0;
    end
  end

  beat_t w_beat;
`ifdef CROSSBAR_IDX_CHECK_EN
  localparam logic [IDX_W:0] N_CONT_L = (IDX_W+1)'(N_CONT);
  logic w_idx_bad;
`endif

  // NOTE: every variable written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin : p_decode
    logic [7:0]        op;
    logic [IDX_W-1:0]  sa, sb, sc;
    logic [CONT_W-1:0] imm, dfield, va, vb, vc;
    a_sel_e            a_sel;
    b_sel_e            b_sel;
    c_sel_e            c_sel;
    d_sel_e            d_sel;
`ifdef CROSSBAR_IDX_CHECK_EN
    logic              bad_a, bad_b, bad_c;
    w_idx_bad = 1'b0;
`endif
    w_beat     = '0;
    w_beat.rem = phv_in[REM_W-1:0];
    w_beat.act = action_in;
    for (int k = 0; k < N_CONT; k++) begin
      op     = action_in[(k+1)*ACT_LEN+ACT_LEN-1 -: 8];
      sa     = action_in[(k+1)*ACT_LEN+ACT_LEN-9 -: IDX_W];
      sb     = action_in[(k+1)*ACT_LEN+ACT_LEN-9-IDX_W -: IDX_W];
      sc     = action_in[(k+1)*ACT_LEN+ACT_LEN-9-2*IDX_W -: IDX_W];
      imm    = action_in[(k+1)*ACT_LEN +: CONT_W];
      dfield = action_in[(k+1)*ACT_LEN+6 +: CONT_W];
      va     = w_cont[sa];
      vb     = w_cont[sb];
      vc     = w_cont[sc];

      a_sel = A_SELF;
      b_sel = B_ZERO;
      c_sel = C_SELF;
      d_sel = D_SELF;
      case (op)
        8'h01, 8'h02, 8'h04, 8'h06, 8'h08,
        8'h0B, 8'h12, 8'h13, 8'h18, 8'h1C: begin a_sel = A_SA;   b_sel = B_SB;  end
        8'h03, 8'h05, 8'h07, 8'h09,
        8'h0A, 8'h17, 8'h1B, 8'h1D:        begin a_sel = A_SA;   b_sel = B_IMM; end
        8'h0E:                             begin a_sel = A_ZERO; b_sel = B_IMM; end
        8'h14:                             begin a_sel = A_SA;   b_sel = B_ZERO; end
        8'h10: begin a_sel = A_SA; b_sel = B_SB;   c_sel = C_SC;  end
        8'h11: begin a_sel = A_SA; b_sel = B_SB;   c_sel = C_IMM; end
        8'h0C: begin a_sel = A_SA; b_sel = B_ZERO; c_sel = C_SC; d_sel = D_DFIELD; end
        default: ;
      endcase

`ifdef CROSSBAR_IDX_CHECK_EN
      // Out-of-range indices fall back to container 0; only sources the
      // opcode actually uses can raise the error.
      bad_a = {1'b0, sa} >= N_CONT_L;
      bad_b = {1'b0, sb} >= N_CONT_L;
      bad_c = {1'b0, sc} >= N_CONT_L;
      if (bad_a) va = w_cont[0];
      if (bad_b) vb = w_cont[0];
      if (bad_c) vc = w_cont[0];
      if ((a_sel == A_SA && bad_a) || (b_sel == B_SB && bad_b) ||
          (c_sel == C_SC && bad_c))
        w_idx_bad = 1'b1;
`endif

      case (a_sel)
        A_SA:    w_beat.a[k*CONT_W +: CONT_W] = va;
        A_ZERO:  w_beat.a[k*CONT_W +: CONT_W] = '0;
        default: w_beat.a[k*CONT_W +: CONT_W] = w_cont[k];
      endcase
      case (b_sel)
        B_SB:    w_beat.b[k*CONT_W +: CONT_W] = vb;
        B_IMM:   w_beat.b[k*CONT_W +: CONT_W] = imm;
        default: w_beat.b[k*CONT_W +: CONT_W] = '0;
      endcase
      case (c_sel)
        C_SC:    w_beat.c[k*CONT_W +: CONT_W] = vc;
        C_IMM:   w_beat.c[k*CONT_W +: CONT_W] = imm;
        default: w_beat.c[k*CONT_W +: CONT_W] = w_cont[k];
      endcase
      w_beat.d[k*CONT_W +: CONT_W] = (d_sel == D_DFIELD) ? dfield : w_cont[k];
    end
  end

  // ---------------------------------------------------------------- pipeline
  state_e r_state;
  logic   r_in_ready;
  beat_t  r_out;
  beat_t  r_skid;
  logic   w_accept;

  assign w_accept = in_valid && r_in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_out      <= '0;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) begin
          r_out   <= w_beat;
          r_state <= S_ONE;
        end
        S_ONE: begin
          if (w_accept && out_ready) begin
            r_out <= w_beat;
          end else if (w_accept) begin
            r_state    <= S_FULL;
            r_in_ready <= 1'b0;
          end else if (out_ready) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: if (out_ready) begin
          r_out      <= r_skid;
          r_state    <= S_ONE;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state    <= S_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the skid payload has no reset; it is only read in S_FULL, which is
  // reachable solely after it has been written.
  always_ff @(posedge clk) begin
    if (r_state == S_ONE && w_accept && !out_ready) r_skid <= w_beat;
  end

`ifdef CROSSBAR_IDX_CHECK_EN
  logic r_idx_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_idx_err <= 1'b0;
    else if (w_accept && w_idx_bad)  r_idx_err <= 1'b1;
  end
  assign idx_err = r_idx_err;
`else
  assign idx_err = 1'b0;
`endif

  assign in_ready        = r_in_ready;
  assign out_valid       = (r_state != S_EMPTY);
  assign alu_a           = r_out.a;
  assign alu_b           = r_out.b;
  assign alu_c           = r_out.c;
  assign alu_d           = r_out.d;
  assign phv_remain_data = r_out.rem;
  assign action_out      = r_out.act;

endmodule

// File: tb/tb_crossbar_pipe.sv
module tb_crossbar_pipe;

`ifdef CROSSBAR_IDX_CHECK_EN
  localparam int N  = 48;
`else
  localparam int N  = 64;
`endif
  localparam int CW = 32;
  localparam int RW = 256;
  localparam int AL = 64;
  localparam int PL = N*CW+RW;
  localparam int AWID = AL*(N+1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PL-1:0]   phv;
  logic [AWID-1:0] act;
  logic            in_valid, in_ready, out_valid, out_ready, idx_err;
  logic [N*CW-1:0] alu_a, alu_b, alu_c, alu_d;
  logic [RW-1:0]   phv_remain_data;
  logic [AWID-1:0] action_out;

  int n_checks = 0;
  int n_errors = 0;

  crossbar_pipe #(.N_CONT(N)) dut (
    .clk(clk), .rst_n(rst_n), .phv_in(phv), .action_in(act),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d),
    .phv_remain_data(phv_remain_data), .action_out(action_out),
    .out_valid(out_valid), .out_ready(out_ready), .idx_err(idx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cont(input int k, input logic [31:0] v);
    phv[RW + k*CW +: CW] = v;
  endtask

  task automatic set_slot(input int s, input logic [7:0] op, input logic [5:0] sa,
                          input logic [5:0] sb, input logic [5:0] sc, input logic [37:0] low);
    logic [63:0] slot;
    slot = {op, sa, sb, sc, low};
    act[s*AL +: AL] = slot;
  endtask

  function automatic logic [31:0] opnd(input logic [N*CW-1:0] v, input int k);
    return v[k*CW +: CW];
  endfunction

  // Beat used by the handshake tests: tail and container 0 carry the id,
  // all slots are opcode 00 so alu_a[0] is container 0.
  task automatic load_beat(input int id);
    act = '0;
    phv = '0;
    phv[RW-1:0] = {8{32'(id)}};
    set_cont(0, 32'hB000_0000 + 32'(id));
  endtask

  task automatic check_beat(input string tag, input int id);
    check({tag, "_tail"}, phv_remain_data[63:0], {2{32'(id)}});
    check({tag, "_a0"}, 64'(opnd(alu_a, 0)), 64'(32'hB000_0000 + 32'(id)));
  endtask

  initial begin
    logic [31:0] exp_a0;
    logic        exp_err;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; phv = '0; act = '0;
    tick(); tick();
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_alu_zero",  64'(|{alu_a, alu_b, alu_c, alu_d}), 64'd0);
    check("rst_tail_zero", 64'(|phv_remain_data), 64'd0);
    check("rst_act_zero",  64'(|action_out), 64'd0);
    check("rst_idx_err",   64'(idx_err), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // ---- decode vectors
    for (int k = 0; k < N; k++) set_cont(k, 32'hC000_0000 | 32'(k));
    set_cont(5, 32'h11);
    set_cont(9, 32'h22);
    phv[RW-1:0] = {8{32'h5A5A_0001}};
    act = '0;
    set_slot(1, 8'h01, 6'd5, 6'd9, 6'd0, 38'd0);
    set_slot(2, 8'h03, 6'd9, 6'd0, 6'd0, 38'h1234);
    set_slot(3, 8'h0E, 6'd0, 6'd0, 6'd0, 38'hDEAD_BEEF);
    set_slot(4, 8'h0C, 6'd5, 6'd0, 6'd9, {32'h00AB_CDEF, 6'd0});
    set_slot(5, 8'h10, 6'd5, 6'd9, 6'd0, 38'd0);
    set_slot(6, 8'h11, 6'd9, 6'd5, 6'd0, 38'h55);
    set_slot(7, 8'h14, 6'd5, 6'd0, 6'd0, 38'd0);
    set_slot(8, 8'hFF, 6'd5, 6'd9, 6'd9, 38'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("dec_out_valid", 64'(out_valid), 64'd1);
    check("op01_a", 64'(opnd(alu_a, 0)), 64'h11);
    check("op01_b", 64'(opnd(alu_b, 0)), 64'h22);
    check("op01_c", 64'(opnd(alu_c, 0)), 64'hC000_0000);
    check("op01_d", 64'(opnd(alu_d, 0)), 64'hC000_0000);
    check("op03_a", 64'(opnd(alu_a, 1)), 64'h22);
    check("op03_b", 64'(opnd(alu_b, 1)), 64'h1234);
    check("op0E_a", 64'(opnd(alu_a, 2)), 64'h0);
    check("op0E_b", 64'(opnd(alu_b, 2)), 64'hDEAD_BEEF);
    check("op0C_a", 64'(opnd(alu_a, 3)), 64'h11);
    check("op0C_b", 64'(opnd(alu_b, 3)), 64'h0);
    check("op0C_c", 64'(opnd(alu_c, 3)), 64'h22);
    check("op0C_d", 64'(opnd(alu_d, 3)), 64'h00AB_CDEF);
    check("op10_c", 64'(opnd(alu_c, 4)), 64'hC000_0000);
    check("op10_d", 64'(opnd(alu_d, 4)), 64'hC000_0004);
    check("op11_a", 64'(opnd(alu_a, 5)), 64'h22);
    check("op11_b", 64'(opnd(alu_b, 5)), 64'h11);
    check("op11_c", 64'(opnd(alu_c, 5)), 64'h55);
    check("op14_a", 64'(opnd(alu_a, 6)), 64'h11);
    check("op14_b", 64'(opnd(alu_b, 6)), 64'h0);
    check("opFF_a", 64'(opnd(alu_a, 7)), 64'hC000_0007);
    check("opFF_b", 64'(opnd(alu_b, 7)), 64'h0);
    check("opFF_c", 64'(opnd(alu_c, 7)), 64'hC000_0007);
    check("last_a", 64'(opnd(alu_a, N-1)), 64'(32'hC000_0000 | 32'(N-1)));
    check("tail",   phv_remain_data[63:0], 64'h5A5A_0001_5A5A_0001);
    check("act_out_eq", 64'(action_out === act), 64'd1);
    check("act_slot4",  action_out[4*AL +: AL], {8'h0C, 6'd5, 6'd0, 6'd9, 32'h00AB_CDEF, 6'd0});
    tick();
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_in_ready",  64'(in_ready), 64'd1);

    // ---- back-pressure: three beats offered while out_ready is low
    out_ready = 1'b0;
    load_beat(1); in_valid = 1'b1;
    tick();
    check("bp1_out_valid", 64'(out_valid), 64'd1);
    check("bp1_in_ready",  64'(in_ready), 64'd1);
    check_beat("bp1", 1);
    load_beat(2);
    tick();
    check("bp2_in_ready", 64'(in_ready), 64'd0);
    check_beat("bp2_hold", 1);
    load_beat(3);
    tick();
    check("bp3_in_ready", 64'(in_ready), 64'd0);
    check_beat("bp3_hold", 1);
    tick();
    check_beat("bp4_hold", 1);
    out_ready = 1'b1;
    tick();
    check("rel1_in_ready", 64'(in_ready), 64'd1);
    check_beat("rel1", 2);
    tick();
    check("rel2_out_valid", 64'(out_valid), 64'd1);
    check_beat("rel2", 3);
    in_valid = 1'b0;
    tick();
    check("rel3_out_valid", 64'(out_valid), 64'd0);

    // ---- reset while FULL
    out_ready = 1'b0;
    load_beat(4); in_valid = 1'b1;
    tick();
    load_beat(5);
    tick();
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready",  64'(in_ready), 64'd1);
    check("mrst_alu_zero",  64'(|alu_a), 64'd0);
    tick();
    rst_n = 1'b1;
    load_beat(6); out_ready = 1'b1;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check_beat("post_rst", 6);
    in_valid = 1'b0;
    tick();
    check("post_rst_drain", 64'(out_valid), 64'd0);

    // ---- source index 50: out of range for N=48, legal for N=64
    load_beat(7);
    set_cont(9, 32'h22);
    set_slot(1, 8'h01, 6'd50, 6'd9, 6'd0, 38'd0);
`ifdef CROSSBAR_IDX_CHECK_EN
    exp_a0  = 32'hB000_0007;
    exp_err = 1'b1;
`else
    set_cont(50, 32'h5050);
    exp_a0  = 32'h5050;
    exp_err = 1'b0;
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("idx_a0",  64'(opnd(alu_a, 0)), 64'(exp_a0));
    check("idx_b0",  64'(opnd(alu_b, 0)), 64'h22);
    check("idx_err", 64'(idx_err), 64'(exp_err));
    load_beat(8); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_beat("idx_next", 8);
    tick(); tick();
    check("idx_err_sticky", 64'(idx_err), 64'(exp_err));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
